// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one combinational FP add/sub unit between two
// requesters; operands are held for ISSUE_CYCLES before the result is captured.
`timescale 1ns/1ps
module fp_addsub_arbiter #(
    parameter int ISSUE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic        req1_sub,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp_data,
    output logic [31:0] add_A_o,
    output logic [31:0] add_B_o,
    output logic        add_sel_o,
    input  logic [31:0] add_result_i,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [3:0] LAST = 4'(ISSUE_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic        rr_ptr;
    logic        owner;
    logic        grant;
    logic        accept;
    logic        capture;
    logic [3:0]  cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sel;
    logic [31:0] result;

    // A lone requester wins outright; contention falls back to rr_ptr.
    always_comb begin
        grant = rr_ptr;
        if (req0_valid && !req1_valid)
            grant = 1'b0;
        else if (req1_valid && !req0_valid)
            grant = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        unique case (state)
            IDLE: begin
                req0_ready = rst_n && !grant && req0_valid;
                req1_ready = rst_n && grant && req1_valid;
                accept     = req0_ready || req1_ready;
                if (accept)
                    state_nx = ISSUE;
            end
            ISSUE: begin
                if (cnt == LAST) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                resp0_valid = !owner;
                resp1_valid = owner;
                if (owner ? resp1_ready : resp0_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
            owner  <= 1'b0;
            cnt    <= 4'd0;
            op_a   <= 32'd0;
            op_b   <= 32'd0;
            op_sel <= 1'b0;
            result <= 32'd0;
        end else begin
            if (accept) begin
                op_a   <= grant ? req1_A : req0_A;
                op_b   <= grant ? req1_B : req0_B;
                op_sel <= grant ? req1_sub : req0_sub;
                owner  <= grant;
                rr_ptr <= !grant;
                cnt    <= 4'd0;
            end else if (state == ISSUE) begin
                cnt <= cnt + 4'd1;
            end
            if (capture)
                result <= add_result_i;
        end
    end

    assign add_A_o   = op_a;
    assign add_B_o   = op_b;
    assign add_sel_o = op_sel;
    assign resp_data = result;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Randomized bench for fp_addsub_arbiter against a transaction-level model;
// two instances (ISSUE_CYCLES 1 and 3) are exercised one after the other.
`timescale 1ns/1ps
module tb_fp_addsub_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn [2];
    logic [1:0]  rv [2];
    logic [31:0] ra [2][2];
    logic [31:0] rb [2][2];
    logic [1:0]  rs [2];
    logic [1:0]  pr [2];
    wire  [1:0]  rdy [2];
    wire  [1:0]  pv [2];
    wire  [31:0] rdata [2];
    wire  [31:0] aa [2];
    wire  [31:0] ab [2];
    wire         asel [2];
    wire         bsy [2];
    wire  [31:0] ares [2];

    int checks = 0;
    int failures = 0;
    bit run = 0;
    int cur = 0;

    function automatic real f2r(input logic [31:0] a);
        logic [63:0] b;
        if (a[30:23] == 8'd0) return 0.0;
        b = {a[31], {3'b000, a[30:23]} + 11'd896, a[22:0], 29'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] r2f(input real z);
        logic [63:0] b;
        logic [10:0] e;
        if (z == 0.0) return 32'd0;
        b = $realtobits(z);
        e = b[62:52];
        if (e < 11'd897) return {b[63], 31'd0};
        if (e > 11'd1150) return {b[63], 8'hff, 23'd0};
        return {b[63], 8'(e - 11'd896), b[51:29]};
    endfunction

    // Stand-in for the external combinational adder
    function automatic logic [31:0] fp_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic s);
        real x;
        real y;
        x = f2r(a);
        y = f2r(b);
        return r2f(s ? x - y : x + y);
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'(120 + $urandom % 16), 23'($urandom)};
    endfunction

    function automatic int ic_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign ares[g] = fp_add(aa[g], ab[g], asel[g]);
        fp_addsub_arbiter #(.ISSUE_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clk          (clk),
            .rst_n        (rstn[g]),
            .req0_valid   (rv[g][0]),
            .req0_ready   (rdy[g][0]),
            .req0_A       (ra[g][0]),
            .req0_B       (rb[g][0]),
            .req0_sub     (rs[g][0]),
            .req1_valid   (rv[g][1]),
            .req1_ready   (rdy[g][1]),
            .req1_A       (ra[g][1]),
            .req1_B       (rb[g][1]),
            .req1_sub     (rs[g][1]),
            .resp0_valid  (pv[g][0]),
            .resp0_ready  (pr[g][0]),
            .resp1_valid  (pv[g][1]),
            .resp1_ready  (pr[g][1]),
            .resp_data    (rdata[g]),
            .add_A_o      (aa[g]),
            .add_B_o      (ab[g]),
            .add_sel_o    (asel[g]),
            .add_result_i (ares[g]),
            .busy         (bsy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t got=%h exp=%h",
                     tag, cur, $time, got, exp);
        end
    endtask

    // Transaction model: one op in flight, response due ISSUE_CYCLES+1
    // cycles after its accept, grants alternate under contention.
    int          cyc = 0;
    int          acc_cyc = 0;
    int          owner = 0;
    int          pick;
    bit          inflight = 0;
    bit          last = 1;
    bit          pre;
    logic [1:0]  expr;
    logic [1:0]  ep;
    logic [31:0] exp_d;
    logic [31:0] ha;
    logic [31:0] hb;
    logic        hs;
    int          resp_cnt [2];
    int          acc_log [$];

    always @(negedge clk) begin
        if (run) begin
            cyc++;
            if (!rstn[cur]) begin
                check("rst_ready", 32'(rdy[cur]), 32'd0);
                check("rst_busy", 32'(bsy[cur]), 32'd0);
                check("rst_resp", 32'(pv[cur]), 32'd0);
                check("rst_data", rdata[cur], 32'd0);
                check("rst_add_a", aa[cur], 32'd0);
                inflight = 0;
                last = 1;
            end else begin
                pre = inflight;
                check("busy", 32'(bsy[cur]), 32'(pre));
                expr = 2'b00;
                pick = 0;
                if (!pre && rv[cur] != 2'b00) begin
                    if (rv[cur] == 2'b11)
                        pick = last ? 0 : 1;
                    else
                        pick = rv[cur][1] ? 1 : 0;
                    expr = pick ? 2'b10 : 2'b01;
                end
                check("ready", 32'(rdy[cur]), 32'(expr));
                if (pre && cyc > acc_cyc) begin
                    check("add_a_hold", aa[cur], ha);
                    check("add_b_hold", ab[cur], hb);
                    check("add_sel_hold", 32'(asel[cur]), 32'(hs));
                end
                ep = 2'b00;
                if (pre && cyc >= acc_cyc + ic_of(cur) + 1) begin
                    ep = owner ? 2'b10 : 2'b01;
                    check("resp_data", rdata[cur], exp_d);
                    if (pr[cur][owner]) begin
                        inflight = 0;
                        resp_cnt[owner]++;
                    end
                end
                check("resp_valid", 32'(pv[cur]), 32'(ep));
                if (expr != 2'b00) begin
                    inflight = 1;
                    owner = pick;
                    last = pick[0];
                    acc_cyc = cyc;
                    ha = ra[cur][pick];
                    hb = rb[cur][pick];
                    hs = rs[cur][pick];
                    exp_d = fp_add(ha, hb, hs);
                    acc_log.push_back(pick);
                end
            end
        end
    end

    logic [1:0]  took;
    logic [1:0]  spv;
    logic [31:0] srd;

    task automatic tick();
        @(negedge clk);
        took = rv[cur] & rdy[cur];
        spv = pv[cur];
        srd = rdata[cur];
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn[cur] = 1'b0;
        repeat (2) tick();
        rstn[cur] = 1'b1;
        tick();
    endtask

    task automatic wait_accept(input int r);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!took[r] && n < 60);
        check("accept", 32'(took[r]), 32'd1);
    endtask

    task automatic op(input int r, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [31:0] expv);
        int n;
        rv[cur][r] = 1'b1;
        ra[cur][r] = a;
        rb[cur][r] = b;
        rs[cur][r] = s;
        wait_accept(r);
        rv[cur][r] = 1'b0;
        ra[cur][r] = rnd_fp();
        rb[cur][r] = rnd_fp();
        rs[cur][r] = ~s;
        n = 0;
        do begin
            tick();
            n++;
        end while (spv == 2'b00 && n < 60);
        check("latency", 32'(n), 32'(ic_of(cur) + 1));
        check("resp_mask", 32'(spv), r ? 32'd2 : 32'd1);
        check("resp_value", srd, expv);
    endtask

    task automatic new_op(input int r);
        ra[cur][r] = rnd_fp();
        rb[cur][r] = rnd_fp();
        rs[cur][r] = 1'($urandom);
    endtask

    task automatic suite();
        int n;
        int c [2];
        logic [31:0] held;

        do_reset();
        op(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        op(1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000);
        op(0, 32'h40A00000, 32'hC0400000, 1'b1, 32'h41000000);

        // both requesters saturated straight out of reset
        do_reset();
        acc_log.delete();
        resp_cnt[0] = 0;
        resp_cnt[1] = 0;
        c[0] = 0;
        c[1] = 0;
        pr[cur] = 2'b11;
        new_op(0);
        new_op(1);
        rv[cur] = 2'b11;
        n = 0;
        while ((c[0] < 4 || c[1] < 4) && n < 300) begin
            tick();
            n++;
            for (int r = 0; r < 2; r++) begin
                if (took[r]) begin
                    c[r]++;
                    if (c[r] == 4) rv[cur][r] = 1'b0;
                    else new_op(r);
                end
            end
        end
        check("fair_done", 32'(n < 300), 32'd1);
        repeat (8) tick();
        check("fair_count", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < acc_log.size() && i < 8; i++)
            check("fair_order", 32'(acc_log[i]), 32'(i % 2));
        check("fair_resp0", 32'(resp_cnt[0]), 32'd4);
        check("fair_resp1", 32'(resp_cnt[1]), 32'd4);

        // response backpressure with a competing request
        pr[cur] = 2'b10;
        op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
        held = srd;
        new_op(1);
        rv[cur][1] = 1'b1;
        repeat (5) begin
            tick();
            check("bp_valid", 32'(spv), 32'd1);
            check("bp_data", srd, held);
            check("bp_no_accept", 32'(took[1]), 32'd0);
        end
        pr[cur] = 2'b11;
        tick();
        check("bp_hs_no_accept", 32'(took[1]), 32'd0);
        tick();
        check("bp_accept1", 32'(took[1]), 32'd1);
        rv[cur][1] = 1'b0;
        repeat (8) tick();

        // reset while an op is issuing
        new_op(0);
        rv[cur][0] = 1'b1;
        wait_accept(0);
        rv[cur][0] = 1'b0;
        rstn[cur] = 1'b0;
        #1;
        check("midrst_busy", 32'(bsy[cur]), 32'd0);
        tick();
        rstn[cur] = 1'b1;
        repeat (ic_of(cur) + 3) begin
            tick();
            check("midrst_no_resp", 32'(spv), 32'd0);
        end
        new_op(0);
        new_op(1);
        rv[cur] = 2'b11;
        tick();
        check("midrst_rr", 32'(took), 32'd1);
        rv[cur][0] = 1'b0;
        op(1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (took[r] || !rv[cur][r]) begin
                    rv[cur][r] = ($urandom % 3) != 0;
                    new_op(r);
                end
            end
            pr[cur] = 2'($urandom) | 2'($urandom);
            tick();
        end
        rv[cur] = 2'b00;
        pr[cur] = 2'b11;
        repeat (10) tick();
        check("drained", 32'(inflight), 32'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0;
            rv[d] = 2'b00;
            rs[d] = 2'b00;
            pr[d] = 2'b11;
            for (int r = 0; r < 2; r++) begin
                ra[d][r] = 32'd0;
                rb[d][r] = 32'd0;
            end
        end
        took = 2'b00;
        spv = 2'b00;
        srd = 32'd0;
        @(posedge clk);
        #1;
        run = 1;
        for (int d = 0; d < 2; d++) begin
            cur = d;
            suite();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_addsub_arbiter.md
Name: fp_addsub_arbiter

Overview:
- Shares one combinational FP_AddSub instance between two requesters, e.g. the SQRT iteration engine and a normalisation/accumulate path.
- Performs round-robin arbitration and accepts operands with a valid/ready handshake.
- Holds registered operands stable on the adder for a programmable number of settle cycles, captures the result, and returns it with a valid/ready response handshake.
- Sits between the requesters and the adder; the adder itself is instantiated outside this block.

Parameters:
- ISSUE_CYCLES, 1, cycles the operands are held on the adder before the result is captured (1..15); sets the adder multicycle path.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_A  input  32  requester 0 operand A (IEEE-754 single)
- req0_B  input  32  requester 0 operand B
- req0_sub  input  1  requester 0: 1 = A-B, 0 = A+B
- req1_valid, req1_ready, req1_A, req1_B, req1_sub  same as requester 0, for requester 1
- resp0_valid  output  1  result ready for requester 0
- resp0_ready  input  1  requester 0 takes result
- resp1_valid  output  1  result ready for requester 1
- resp1_ready  input  1  requester 1 takes result
- resp_data  output  32  result word (shared by both responses)
- add_A_o  output  32  to adder data_iA
- add_B_o  output  32  to adder data_iB
- add_sel_o  output  1  to adder AddSub_Sel
- add_result_i  input  32  from adder data_o
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, rr_ptr = 0 (requester 0 has priority), owner = 0, cnt = 0.
  - Operand registers, result register and resp_data are all 0.
  - resp0_valid, resp1_valid and busy are 0.
  - reqN_ready is forced 0 while rst_n is low.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant: if only one reqN_valid is high, grant N. If both are high, grant rr_ptr.
  - reqN_ready = (state==IDLE) & grant==N & reqN_valid. This is combinational; at most one ready is high per cycle.
  - On the accept edge: latch reqN_A, reqN_B and reqN_sub into the operand registers, owner = N, rr_ptr = ~N, cnt = 0, go to ISSUE.
  - With no valid request the state stays IDLE and rr_ptr is unchanged.
- ISSUE:
  - add_A_o, add_B_o and add_sel_o drive the operand registers. They are stable from the first ISSUE cycle until the next accept.
  - cnt increments each cycle.
  - When cnt == ISSUE_CYCLES-1: capture add_result_i into resp_data and go to RESP.
  - Accept-to-response latency is ISSUE_CYCLES+1 cycles.
- RESP:
  - resp{owner}_valid = 1; the other resp valid = 0; resp_data is held.
  - Leave to IDLE on the edge where resp{owner}_ready is high. A new accept is possible in the following cycle.
  - Ready held low keeps the state in RESP indefinitely with data stable; no new request is accepted.
- Outside ISSUE, add_* keep their last operand values. The adder is combinational, so this is harmless.
- Requester obligations: a requester keeps valid and operands stable until ready. A requester's operands may change after acceptance without affecting the in-flight op.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- Simultaneous events:
  - reqN_valid rising in the same cycle as a RESP exit is not accepted until the IDLE cycle.
  - resp ready asserted while resp valid is low has no effect.
- Reset mid-operation: the in-flight op is discarded and no response is issued. After release the block is in IDLE with rr_ptr = 0.
- Peak throughput: one op per ISSUE_CYCLES+2 cycles.

Test Plan:
- Single op, ISSUE_CYCLES=1, real FP_AddSub attached: req0 A=0x3F800000, B=0x3F800000, sub=0 → req0_ready in cycle 0, resp0_valid in cycle 2, resp_data=0x40000000.
- Subtract on requester 1: A=0x40400000, B=0x3F800000, sub=1 → resp1_valid only, resp_data=0x40000000, resp0_valid stays 0.
- Both valid from reset, 4 ops each, resp ready tied high → accept order 0,1,0,1,…; 8 responses, each routed to the correct requester, no overlap.
- Backpressure: hold resp0_ready=0 for 5 cycles with req1_valid high → resp0_valid and resp_data stable, req1_ready stays 0; req1 accepted the cycle after resp0_ready rises.
- ISSUE_CYCLES=3 → add_A_o, add_B_o, add_sel_o stable 3 cycles; resp valid 4 cycles after accept; changing req0_A after accept does not alter the result.
- Assert rst_n=0 during ISSUE → busy=0, no resp valid; a following req1 op completes normally with rr_ptr restarted at 0.
